// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single-precision divider: 25-step restoring mantissa division, truncating.
// Define FDIV_SPECIAL_CASE_EN to resolve zero/inf/NaN operands at accept time without iterating.
module fdiv_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out
);

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    state_t       state_q, state_d;
    logic [24:0]  rem_q, rem_d;
    logic [23:0]  div_q, div_d;
    logic [24:0]  quo_q, quo_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [7:0]   aexp_q, aexp_d;
    logic [7:0]   bexp_q, bexp_d;
    logic         sign_q, sign_d;
    logic [N-1:0] out_q, out_d;
    logic [23:0]  diff;
    logic         accept;

    // Exponent rebias, one-bit normalisation and zero/infinity saturation of the raw quotient.
    function automatic logic [N-1:0] pack_result(input logic sign, input logic [7:0] ea,
                                                 input logic [7:0] eb, input logic [24:0] q);
        logic signed [9:0] e;
        logic [22:0]       m;
        e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        if (q[24]) begin
            m = q[23:1];
        end else begin
            m = q[22:0];
            e = e - 10'sd1;
        end
        if (ea == 8'd0 || e <= 10'sd0)
            return {sign, 31'h0};
        else if (e >= 10'sd255)
            return {sign, 8'hFF, 23'h0};
        else
            return {sign, e[7:0], m};
    endfunction

`ifdef FDIV_SPECIAL_CASE_EN
    // Returns {is_special, result}; is_special=0 means the operands need the iterative path.
    function automatic logic [N:0] special_case(input logic [N-1:0] x, input logic [N-1:0] y);
        logic xn, yn, xi, yi, xz, yz, s;
        xn = (&x[30:23]) && (|x[22:0]);
        yn = (&y[30:23]) && (|y[22:0]);
        xi = (&x[30:23]) && !(|x[22:0]);
        yi = (&y[30:23]) && !(|y[22:0]);
        xz = !(|x[30:23]);
        yz = !(|y[30:23]);
        s  = x[31] ^ y[31];
        if (xn || yn || (xz && yz) || (xi && yi))
            return {1'b1, 32'h7FC00000};
        else if (yz)
            return {1'b1, s, 8'hFF, 23'h0};
        else if (xz || yi)
            return {1'b1, s, 31'h0};
        else if (xi)
            return {1'b1, s, 8'hFF, 23'h0};
        else
            return {1'b0, 32'h0};
    endfunction

    logic [N:0] spec;
    assign spec = special_case(a, b);
`endif

    assign accept    = in_valid && (state_q == IDLE);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        aexp_d  = aexp_q;
        bexp_d  = bexp_q;
        sign_d  = sign_q;
        out_d   = out_q;
        // Only used when rem >= div, where the true difference fits in 24 bits.
        diff    = rem_q[23:0] - div_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_d   = {2'b01, a[22:0]};
                    div_d   = {1'b1, b[22:0]};
                    quo_d   = '0;
                    cnt_d   = 5'd24;
                    aexp_d  = a[30:23];
                    bexp_d  = b[30:23];
                    sign_d  = a[31] ^ b[31];
                    state_d = CALC;
`ifdef FDIV_SPECIAL_CASE_EN
                    if (spec[N]) begin
                        out_d   = spec[N-1:0];
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (rem_q >= {1'b0, div_q}) begin
                    quo_d = {quo_q[23:0], 1'b1};
                    rem_d = {diff, 1'b0};
                end else begin
                    quo_d = {quo_q[23:0], 1'b0};
                    rem_d = {rem_q[23:0], 1'b0};
                end
                if (cnt_q == 5'd0)
                    state_d = NORM;
                else
                    cnt_d = cnt_q - 5'd1;
            end
            NORM: begin
                out_d   = pack_result(sign_q, aexp_q, bexp_q, quo_q);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            aexp_q  <= '0;
            bexp_q  <= '0;
            sign_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            aexp_q  <= aexp_d;
            bexp_q  <= bexp_d;
            sign_q  <= sign_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Scoreboard bench for fdiv_seq: random and directed divisions against a real-valued reference.
`timescale 1ns/1ps
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, out;

    fdiv_seq #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        prev_vld = 1'b0;
    logic [31:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: quotient = ma/mb * 2^(ea-eb), mantissa taken as floor of the scaled ratio.
    // lat = cycle (counting the accept edge as cycle 0) in which out_valid first appears.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output int lat);
        int     ea, eb, e;
        longint ma, mb, m;
        logic   s;
`ifdef FDIV_SPECIAL_CASE_EN
        logic   xn, yn, xi, yi, xz, yz;
`endif
        s   = x[31] ^ y[31];
        ea  = int'(x[30:23]);
        eb  = int'(y[30:23]);
        lat = 27;
`ifdef FDIV_SPECIAL_CASE_EN
        xz = (ea == 0);
        yz = (eb == 0);
        xi = (ea == 255) && (x[22:0] == 0);
        yi = (eb == 255) && (y[22:0] == 0);
        xn = (ea == 255) && (x[22:0] != 0);
        yn = (eb == 255) && (y[22:0] != 0);
        lat = 1;
        if (xn || yn || (xz && yz) || (xi && yi)) begin r = 32'h7FC00000; return; end
        if (yz) begin r = {s, 8'hFF, 23'h0}; return; end
        if (xz || yi) begin r = {s, 31'h0}; return; end
        if (xi) begin r = {s, 8'hFF, 23'h0}; return; end
        lat = 27;
`endif
        if (ea == 0) begin r = {s, 31'h0}; return; end
        ma = longint'({1'b1, x[22:0]});
        mb = longint'({1'b1, y[22:0]});
        if (ma >= mb) begin
            e = ea - eb + 127;
            m = (ma << 23) / mb;
        end else begin
            e = ea - eb + 126;
            m = (ma << 24) / mb;
        end
        if (e <= 0)        r = {s, 31'h0};
        else if (e >= 255) r = {s, 8'hFF, 23'h0};
        else               r = {s, 8'(e), m[22:0]};
    endfunction

    // Monitor: pops the scoreboard on each handshake, checks latency, hold stability, in_ready.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else if (out_valid) begin
            check("in_ready_low_in_done", {31'h0, in_ready}, 32'h0);
            check("out_valid_with_pending", (sb.size() > 0) ? 32'h1 : 32'h0, 32'h1);
            if (sb.size() > 0) begin
                if (!prev_vld)
                    check("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                else
                    check("hold_stable", out, held);
                if (out_ready) begin
                    check("quotient", out, sb[0].res);
                    void'(sb.pop_front());
                end
            end
            held     = out;
            prev_vld = !out_ready;
        end else begin
            prev_vld = 1'b0;
        end
    end

    task automatic recover();
        rst_n = 1'b0;
        sb.delete();
        #2 rst_n = 1'b1;
        prev_vld = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic rdy);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("in_ready_before_issue", {31'h0, in_ready}, 32'h1);
        a = x; b = y; in_valid = 1'b1; out_ready = rdy;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model(x, y, e.res, e.lat);
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic do_div(input logic [31:0] x, input logic [31:0] y, input int hold);
        int n = 0;
        issue(x, y, hold == 0);
        while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
        check("out_valid_within_budget", {31'h0, out_valid}, 32'h1);
        if (!out_valid) begin recover(); return; end
        for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("out_valid_single_handshake", {31'h0, out_valid}, 32'h0);
        check("in_ready_back_in_idle", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        logic [31:0] x, y;
        int          n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        #12;
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_out", out, 32'h0);
        check("reset_in_ready", {31'h0, in_ready}, 32'h1);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        do_div(32'h40C00000, 32'h40000000, 0);
        do_div(32'h3F800000, 32'h40400000, 0);
        do_div(32'hC0800000, 32'h40000000, 10);
        do_div(32'h7F000000, 32'h00800000, 0);
        do_div(32'h00800000, 32'h7F000000, 0);
        do_div(32'h80000000, 32'h40000000, 0);
        do_div(32'h3F800000, 32'h3F800000, 2);
        do_div(32'hBF7FFFFF, 32'h3F800001, 0);

        // Reset pulse during CALC abandons the division.
        issue(32'h40C00000, 32'h40000000, 1'b1);
        for (int i = 0; i < 11; i++) @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        #2;
        check("abort_out_valid_in_reset", {31'h0, out_valid}, 32'h0);
        check("abort_in_ready_in_reset", {31'h0, in_ready}, 32'h1);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 30; i++) @(posedge clk);
        #1;
        check("abort_in_ready_after", {31'h0, in_ready}, 32'h1);
        check("abort_out_valid_after", {31'h0, out_valid}, 32'h0);
        do_div(32'h40C00000, 32'h40000000, 0);

`ifdef FDIV_SPECIAL_CASE_EN
        do_div(32'h3F800000, 32'h00000000, 0);
        do_div(32'h00000000, 32'h00000000, 0);
        do_div(32'h7FC00001, 32'h3F800000, 0);
        do_div(32'hFF800000, 32'h40000000, 1);
        do_div(32'h40000000, 32'hFF800000, 0);
        do_div(32'h7F800000, 32'h7F800000, 0);
`endif

        for (int k = 0; k < 40; k++) begin
            x = $urandom;
            y = $urandom;
            if (k % 5 != 0) begin
                x[30:23] = 8'($urandom_range(180, 70));
                y[30:23] = 8'($urandom_range(180, 70));
            end else begin
                x[30:23] = 8'($urandom_range(254, 1));
                y[30:23] = 8'($urandom_range(254, 1));
            end
            if (k % 13 == 7) x[30:23] = 8'h00;
            do_div(x, y, ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 1)) : 0);
        end

        n = 0;
        while (sb.size() > 0 && n < 200) begin @(posedge clk); n++; end
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
